regfile_dp: RTL and testbench

// - Datapath register file and status-flag register for mycpu.
// - Sits directly upstream of the function unit and supplies its A and B operands.
// - Captures the function unit's result and Z/N flags on the write-back edge,

---
 rtl/mycpu_pkg.sv | 11 +
 rtl/status_flags.sv | 25 ++
 rtl/regfile_dp.sv | 68 ++++++
 tb/tb_regfile_dp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mycpu_pkg.sv
// Shared datapath sizes and types for mycpu.
package mycpu_pkg;

  localparam int unsigned DW    = 16;
  localparam int unsigned NREGS = 8;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef logic [DW-1:0] word_t;
  typedef logic [AW-1:0] reg_addr_t;

endpackage

// File: rtl/status_flags.sv
// Two-bit enable register holding the Z/N status flags; async active-low reset.
module status_flags (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] d,
  output logic [1:0] q
);

  logic [1:0] q_q;
  logic [1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (en) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= 2'b00;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/regfile_dp.sv
// Datapath register file with combinational A/B reads and registered Z/N flags.
// Optional same-cycle write forwarding to the read ports: RF_WRITE_BYPASS_EN.
module regfile_dp
  import mycpu_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_in,
  input  logic          z_in,
  input  logic          n_in,
  input  logic          wr_en,
  input  logic          flag_en,
  input  logic [AW-1:0] dsel,
  input  logic [AW-1:0] asel,
  input  logic [AW-1:0] bsel,
  input  logic          mb_sel,
  input  logic [DW-1:0] const_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic          z_out,
  output logic          n_out
);

  word_t regs_q [NREGS];
  word_t regs_d [NREGS];
  logic [1:0] flags;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[dsel] = d_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_comb begin
    a_out = regs_q[asel];
    b_out = regs_q[bsel];
`ifdef RF_WRITE_BYPASS_EN
    if (wr_en && (dsel == asel)) a_out = d_in;
    if (wr_en && (dsel == bsel)) b_out = d_in;
`endif
    // Immediate wins over any register or forwarded value.
    if (mb_sel) b_out = const_in;
  end

  status_flags u_status_flags (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (flag_en),
    .d     ({z_in, n_in}),
    .q     (flags)
  );

  assign z_out = flags[1];
  assign n_out = flags[0];

`ifndef SYNTHESIS
  a_dsel_known: assert property (@(posedge clk) disable iff (!rst_n)
    wr_en |-> !$isunknown(dsel));
`endif

endmodule

// File: tb/tb_regfile_dp.sv
// Self-checking bench for regfile_dp: array model checked every cycle plus directed literals.
module tb_regfile_dp;
  import mycpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] d_in, const_in, a_out, b_out;
  logic        z_in, n_in, wr_en, flag_en, mb_sel, z_out, n_out;
  logic [2:0]  dsel, asel, bsel;

  int total = 0;
  int bad   = 0;

`ifdef RF_WRITE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  regfile_dp dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d_in     (d_in),
    .z_in     (z_in),
    .n_in     (n_in),
    .wr_en    (wr_en),
    .flag_en  (flag_en),
    .dsel     (dsel),
    .asel     (asel),
    .bsel     (bsel),
    .mb_sel   (mb_sel),
    .const_in (const_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .z_out    (z_out),
    .n_out    (n_out)
  );

  always #5 clk = ~clk;

  // Reference model: plain array of register contents and two flag bits.
  logic [15:0] m_reg [8];
  logic        m_z, m_n;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_reg[i] = 16'h0000;
      m_z = 1'b0;
      m_n = 1'b0;
    end else begin
      if (wr_en) m_reg[dsel] = d_in;
      if (flag_en) begin
        m_z = z_in;
        m_n = n_in;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    logic [15:0] ea, eb;
    ea = m_reg[asel];
    eb = m_reg[bsel];
    if (Bypass && rst_n && wr_en && dsel == asel) ea = d_in;
    if (Bypass && rst_n && wr_en && dsel == bsel) eb = d_in;
    if (mb_sel) eb = const_in;
    chk("model_a", a_out, ea);
    chk("model_b", b_out, eb);
    chk("model_z", {15'd0, z_out}, {15'd0, m_z});
    chk("model_n", {15'd0, n_out}, {15'd0, m_n});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [2:0] r, input logic [15:0] v);
    wr_en = 1'b1;
    dsel  = r;
    d_in  = v;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; d_in = '0; const_in = '0; z_in = 0; n_in = 0;
    wr_en = 0; flag_en = 0; dsel = '0; asel = '0; bsel = '0; mb_sel = 0;
    repeat (2) tick();
    rst_n = 1'b1;
    #1;
    chk("rst_a", a_out, 16'h0000);
    chk("rst_z", {15'd0, z_out}, 16'h0000);
    chk("rst_n_flag", {15'd0, n_out}, 16'h0000);

    // Async reset mid-cycle clears a loaded register immediately.
    write(3'd3, 16'h1234);
    asel = 3'd3;
    #1 chk("r3_loaded", a_out, 16'h1234);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_a", a_out, 16'h0000);
    chk("async_rst_z", {15'd0, z_out}, 16'h0000);
    // Reset held across an edge with a write pending: no write.
    wr_en = 1'b1; dsel = 3'd3; d_in = 16'h5555;
    tick();
    wr_en = 1'b0; rst_n = 1'b1;
    #1 chk("rst_beats_wr", a_out, 16'h0000);

    // Write then read, with same-cycle read.
    tick();
    wr_en = 1'b1; dsel = 3'd5; d_in = 16'hBEEF; asel = 3'd5;
    #1 chk("same_cycle_rd", a_out, Bypass ? 16'hBEEF : 16'h0000);
    tick();
    wr_en = 1'b0;
    #1 chk("next_cycle_rd", a_out, 16'hBEEF);

    // B mux.
    write(3'd2, 16'h00FF);
    bsel = 3'd2; mb_sel = 1'b0;
    #1 chk("b_reg", b_out, 16'h00FF);
    mb_sel = 1'b1; const_in = 16'h7FFF;
    #1 chk("b_const", b_out, 16'h7FFF);
    wr_en = 1'b1; dsel = 3'd2; d_in = 16'hABCD;
    #1 chk("b_const_wr", b_out, 16'h7FFF);
    tick();
    wr_en = 1'b0; mb_sel = 1'b0;
    #1 chk("b_after_wr", b_out, 16'hABCD);

    // Flags load and hold.
    flag_en = 1'b1; z_in = 1'b1; n_in = 1'b0;
    tick();
    flag_en = 1'b0; z_in = 1'b0; n_in = 1'b1;
    #1 chk("z_loaded", {15'd0, z_out}, 16'h0001);
    tick();
    chk("z_held", {15'd0, z_out}, 16'h0001);
    chk("n_held", {15'd0, n_out}, 16'h0000);

    // Loop with FU: FADD then FSUB, FU results computed here.
    write(3'd1, 16'h0003);
    write(3'd2, 16'h0004);
    asel = 3'd1; bsel = 3'd2;
    #1 chk("fu_a", a_out, 16'h0003);
    chk("fu_b", b_out, 16'h0004);
    w = 16'h0003 + 16'h0004;
    d_in = w; z_in = (w == 16'h0); n_in = w[15];
    dsel = 3'd0; wr_en = 1'b1; flag_en = 1'b1;
    tick();
    wr_en = 1'b0; flag_en = 1'b0; asel = 3'd0;
    #1 chk("fadd_r0", a_out, 16'h0007);
    chk("fadd_z", {15'd0, z_out}, 16'h0000);
    chk("fadd_n", {15'd0, n_out}, 16'h0000);
    w = 16'h0003 - 16'h0004;
    d_in = w; z_in = (w == 16'h0); n_in = w[15];
    dsel = 3'd0; wr_en = 1'b1; flag_en = 1'b1;
    tick();
    wr_en = 1'b0; flag_en = 1'b0;
    #1 chk("fsub_r0", a_out, 16'hFFFF);
    chk("fsub_z", {15'd0, z_out}, 16'h0000);
    chk("fsub_n", {15'd0, n_out}, 16'h0001);

    // Port sweep over all asel/bsel pairs.
    for (int k = 0; k < 8; k++) begin
      w = 16'h1111 * 16'(k + 1);
      write(3'(k), w);
    end
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        asel = 3'(i); bsel = 3'(j);
        #1;
        chk("sweep_a", a_out, 16'h1111 * 16'(i + 1));
        chk("sweep_b", b_out, 16'h1111 * 16'(j + 1));
      end
    end

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
